note_sequencer: RTL
===================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 12500000, clocks per duration unit.
REQ-002 SHALL have parameter GAP_CYCLES, default 1250000, silent clocks between notes.
REQ-003 SHALL have parameter SONG_LEN, default 32, number of song ROM entries.
REQ-004 SHALL have parameter ADDR_W, default 5, song ROM address width.
REQ-005 SHALL have port clock  input  1  system clock, 50 MHz.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  begin playback from entry 0 when idle.
REQ-008 SHALL have port stop  input  1  abort playback.
REQ-009 SHALL have port loop_en  input  1  restart at entry 0 after end of song.
REQ-010 SHALL have port rom_addr  output  ADDR_W  song ROM read address.
REQ-011 SHALL have port rom_data  input  10  ROM word {note_code[9:4], duration[3:0]}, valid one clock after rom_addr.
REQ-012 SHALL have port play_note  output  1  enable to the waveform generator.
REQ-013 SHALL have port hz  output  32  waveform period in clocks.
REQ-014 SHALL have port duration  output  4  current note length in beats.
REQ-015 SHALL have port note_reset  output  1  one-cycle pulse that reloads the waveform generator.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at end of song when loop_en=0.

Function
REQ-018 SHALL use FSM states IDLE, FETCH, LOAD, PLAY, GAP.
REQ-019 IDLE: start=1 -> rom_addr=0, go to FETCH; all other inputs ignored.
REQ-020 FETCH: always go to LOAD next clock (ROM read latency = 1).
REQ-021 LOAD with duration==0 (end marker): if loop_en=1, rom_addr=0 and FETCH; else done=1 for 1 clock and IDLE.
REQ-022 LOAD with duration!=0: latch hz=lut(note_code) and duration, pulse note_reset, load beat_cnt=duration*BEAT_CYCLES-1, go to PLAY.
REQ-023 PLAY: play_note=1 if note_code is 1..48, else 0 (rest); beat_cnt decrements by 1 each clock; at 0 load gap_cnt=GAP_CYCLES-1 and go to GAP.
REQ-024 GAP: play_note=0; at gap_cnt==0, rom_addr increments and FSM goes to FETCH.
REQ-025 rom_addr==SONG_LEN-1 leaving GAP SHALL be treated as an end marker (REQ-021 path via LOAD without a ROM read), never wrapping silently.
REQ-026 stop=1 in any state SHALL force IDLE next clock with play_note=0 and busy=0; stop wins over simultaneous start.
REQ-027 start while busy SHALL be ignored.
REQ-028 beat_cnt and gap_cnt SHALL be 32-bit unsigned; 15*BEAT_CYCLES fits without overflow.
REQ-029 The LUT SHALL map note_code 1..48 to C3..B6 in equal temperament, hz=round(50e6/f); code 0 and 49..63 map to 0.
REQ-030 hz and duration SHALL hold their values through GAP and IDLE until the next LOAD.

Reset
REQ-031 On reset: state=IDLE, rom_addr=0, hz=0, duration=0, play_note=0, note_reset=0, busy=0, done=0, and both counters=0.
REQ-032 Reset mid-note SHALL silence play_note on the next clock.

Structure
REQ-033 The FSM state encoding, note-code width, and REST/END constants SHALL live in the shared package music_pkg.
REQ-034 The code-to-period table SHALL be the combinational sub-module note_period_lut.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2, SONG_LEN=4)
REQ-035 ROM {A4/2, rest/1, END}, start pulse -> note_reset at LOAD, hz=113636, play_note high 8 clocks, low 2, then low 4+2; done pulse; busy falls.
REQ-036 ROM entry code 10 duration 1 -> hz=227273, duration=1, play_note high exactly 4 clocks.
REQ-037 loop_en=1 with ROM {C3/1, END} -> rom_addr returns to 0; note_reset recurs every 10 clocks (FETCH+LOAD+4+2+FETCH+LOAD); done never asserts.
REQ-038 stop asserted on the 3rd clock of PLAY -> next clock play_note=0, busy=0; start+stop together in IDLE -> stays IDLE.
REQ-039 Four valid entries and no END marker -> after entry 3's GAP, done pulse and IDLE; rom_addr never exceeds 3.
REQ-040 reset asserted mid-PLAY -> next clock all outputs at REQ-031 values; start afterwards replays from entry 0.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the song sequencer.
// Note codes 1..48 are audible (C3..B6); anything else is silence.
package music_pkg;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 4;

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;
   localparam logic [NOTE_W-1:0] NOTE_MAX  = 6'd48;
   localparam logic [DUR_W-1:0]  DUR_END   = '0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      PLAY,
      GAP
   } seq_state_t;

   function automatic logic note_audible(
      input logic [NOTE_W-1:0] code
   );
      return (code != NOTE_REST) && (code <= NOTE_MAX);
   endfunction

endpackage

// File: rtl/note_period_lut.sv
// Note code to waveform period in 50 MHz clocks, equal temperament.
// Code 1 is C3, code 48 is B6; other codes give a zero period.
module note_period_lut
   import music_pkg::*;
(
   input  logic [NOTE_W-1:0] code,
   output logic [31:0]       period
);

   always_comb begin
      period = '0;
      case (code)
         6'd1  : period = 32'd382226;
         6'd2  : period = 32'd360773;
         6'd3  : period = 32'd340524;
         6'd4  : period = 32'd321412;
         6'd5  : period = 32'd303373;
         6'd6  : period = 32'd286346;
         6'd7  : period = 32'd270274;
         6'd8  : period = 32'd255105;
         6'd9  : period = 32'd240787;
         6'd10 : period = 32'd227273;
         6'd11 : period = 32'd214517;
         6'd12 : period = 32'd202477;
         6'd13 : period = 32'd191113;
         6'd14 : period = 32'd180386;
         6'd15 : period = 32'd170262;
         6'd16 : period = 32'd160706;
         6'd17 : period = 32'd151686;
         6'd18 : period = 32'd143173;
         6'd19 : period = 32'd135137;
         6'd20 : period = 32'd127553;
         6'd21 : period = 32'd120394;
         6'd22 : period = 32'd113636;
         6'd23 : period = 32'd107258;
         6'd24 : period = 32'd101238;
         6'd25 : period = 32'd95556;
         6'd26 : period = 32'd90193;
         6'd27 : period = 32'd85131;
         6'd28 : period = 32'd80353;
         6'd29 : period = 32'd75843;
         6'd30 : period = 32'd71586;
         6'd31 : period = 32'd67569;
         6'd32 : period = 32'd63776;
         6'd33 : period = 32'd60197;
         6'd34 : period = 32'd56818;
         6'd35 : period = 32'd53629;
         6'd36 : period = 32'd50619;
         6'd37 : period = 32'd47778;
         6'd38 : period = 32'd45097;
         6'd39 : period = 32'd42566;
         6'd40 : period = 32'd40177;
         6'd41 : period = 32'd37922;
         6'd42 : period = 32'd35793;
         6'd43 : period = 32'd33784;
         6'd44 : period = 32'd31888;
         6'd45 : period = 32'd30098;
         6'd46 : period = 32'd28409;
         6'd47 : period = 32'd26815;
         6'd48 : period = 32'd25310;
         default : period = '0;
      endcase
   end

endmodule

// File: rtl/note_sequencer.sv
// Walks a song ROM of {note_code, duration} words and drives a tone
// generator; duration 0 or running off the last entry ends the song.
module note_sequencer
   import music_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES = 12500000,
   parameter int unsigned GAP_CYCLES  = 1250000,
   parameter int unsigned SONG_LEN    = 32,
   parameter int unsigned ADDR_W      = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [9:0]        rom_data,
   output logic              play_note,
   output logic [31:0]       hz,
   output logic [3:0]        duration,
   output logic              note_reset,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
   localparam logic [31:0]       GAP_LOAD  = 32'(GAP_CYCLES) - 32'd1;

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       hz_q, hz_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [31:0]       beat_q, beat_d;
   logic [31:0]       gap_q, gap_d;
   logic              play_q, play_d;
   logic              nrst_q, nrst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              eos_q, eos_d;

   logic [NOTE_W-1:0] rom_code;
   logic [DUR_W-1:0]  rom_dur;
   logic [31:0]       lut_hz;

   assign rom_code = rom_data[9:4];
   assign rom_dur  = rom_data[3:0];

   note_period_lut u_lut (
      .code   (rom_code),
      .period (lut_hz)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hz_d    = hz_q;
      dur_d   = dur_q;
      note_d  = note_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      eos_d   = eos_q;
      nrst_d  = 1'b0;
      done_d  = 1'b0;
      if (stop) begin
         state_d = IDLE;
         eos_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_d  = '0;
                  eos_d   = 1'b0;
                  state_d = FETCH;
               end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
               // eos_q marks a song that ran past its last entry
               if (eos_q || rom_dur == DUR_END) begin
                  eos_d = 1'b0;
                  if (loop_en) begin
                     addr_d  = '0;
                     state_d = FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  hz_d    = lut_hz;
                  dur_d   = rom_dur;
                  note_d  = rom_code;
                  nrst_d  = 1'b1;
                  beat_d  = 32'(rom_dur) * BEAT_CYCLES - 32'd1;
                  state_d = PLAY;
               end
            end
            PLAY: begin
               if (beat_q == '0) begin
                  gap_d   = GAP_LOAD;
                  state_d = GAP;
               end else begin
                  beat_d = beat_q - 32'd1;
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  if (addr_q == LAST_ADDR) begin
                     eos_d   = 1'b1;
                     state_d = LOAD;
                  end else begin
                     addr_d  = addr_q + 1'b1;
                     state_d = FETCH;
                  end
               end else begin
                  gap_d = gap_q - 32'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
      play_d = (state_d == PLAY) && note_audible(note_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         hz_q    <= '0;
         dur_q   <= '0;
         note_q  <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
         play_q  <= 1'b0;
         nrst_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eos_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hz_q    <= hz_d;
         dur_q   <= dur_d;
         note_q  <= note_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         play_q  <= play_d;
         nrst_q  <= nrst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         eos_q   <= eos_d;
      end
   end

   assign rom_addr   = addr_q;
   assign hz         = hz_q;
   assign duration   = dur_q;
   assign play_note  = play_q;
   assign note_reset = nrst_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
